// File: rtl/perceptron_host.sv
// Host-side bridge: turns one register request into CMD/ADDR[/DATA] UART bytes and waits for a read reply.
// Latency: one tx byte per available UART slot plus one gap cycle each; reads finish on rx byte or after TIMED+1 wait cycles.
// Backpressure: req_ready only in IDLE; each byte is held until tx_busy is low.
module perceptron_host #(
    parameter int         TIMED     = 2500,
    parameter logic [7:0] CMD_WRITE = 8'h01,
    parameter logic [7:0] CMD_READ  = 8'h02
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_timeout,
    output logic       tx_send,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       rx_recieved,
    input  logic [7:0] rx_data
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CMD     = 3'd1;
    localparam logic [2:0] ADDR    = 3'd2;
    localparam logic [2:0] DATA    = 3'd3;
    localparam logic [2:0] GAP     = 3'd4;
    localparam logic [2:0] WAIT_RX = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    logic [2:0]  state;
    logic [2:0]  gap_next;
    logic        drain;
    logic        wr_q;
    logic [7:0]  addr_q;
    logic [7:0]  wdata_q;
    logic [31:0] cnt;
    logic        send_state;

    always_comb begin
        req_ready  = (state == IDLE);
        rsp_valid  = (state == DONE);
        send_state = (state == CMD) || (state == ADDR) || (state == DATA);
        tx_send    = send_state && !tx_busy;
        case (state)
            CMD:     tx_data = wr_q ? CMD_WRITE : CMD_READ;
            ADDR:    tx_data = addr_q;
            DATA:    tx_data = wdata_q;
            default: tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gap_next    <= IDLE;
            drain       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            cnt         <= 32'd0;
            rsp_rdata   <= 8'h00;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q        <= req_write;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        rsp_rdata   <= 8'h00;
                        rsp_timeout <= 1'b0;
                        state       <= CMD;
                    end
                end
                CMD: begin
                    if (!tx_busy) begin
                        state    <= GAP;
                        gap_next <= ADDR;
                    end
                end
                ADDR: begin
                    if (!tx_busy) begin
                        state    <= GAP;
                        gap_next <= wr_q ? DATA : WAIT_RX;
                    end
                end
                DATA: begin
                    if (!tx_busy) begin
                        state    <= GAP;
                        gap_next <= DONE;
                    end
                end
                GAP: begin
                    // The last write byte must leave the UART before completing;
                    // the first GAP cycle never trusts tx_busy.
                    if (gap_next == DONE) begin
                        if (!drain) begin
                            drain <= 1'b1;
                        end else if (!tx_busy) begin
                            drain <= 1'b0;
                            state <= DONE;
                        end
                    end else begin
                        state <= gap_next;
                        if (gap_next == WAIT_RX) begin
                            cnt <= 32'd0;
                        end
                    end
                end
                WAIT_RX: begin
                    cnt <= cnt + 32'd1;
                    if (rx_recieved) begin
                        rsp_rdata   <= rx_data;
                        rsp_timeout <= 1'b0;
                        state       <= DONE;
                    end else if (cnt == 32'(TIMED)) begin
                        rsp_rdata   <= 8'h00;
                        rsp_timeout <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/perceptron_host.md
PERCEPTRON_HOST -- requirements
Module: perceptron_host

Interface
REQ-001 Parameter TIMED, default 2500, SHALL set the read-response timeout in clk cycles.
REQ-002 Parameter CMD_WRITE, default 8'h01, SHALL be the command byte for a write frame.
REQ-003 Parameter CMD_READ, default 8'h02, SHALL be the command byte for a read frame.
REQ-004 clk  input  1  SHALL be the single clock; all logic on posedge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 req_valid  input  1  SHALL request a transaction.
REQ-007 req_ready  output  1  SHALL indicate the request is accepted this cycle.
REQ-008 req_write  input  1  SHALL select write (1) or read (0).
REQ-009 req_addr  input  8  SHALL carry the register address.
REQ-010 req_wdata  input  8  SHALL carry the write data.
REQ-011 rsp_valid  output  1  SHALL be a one-cycle completion pulse.
REQ-012 rsp_rdata  output  8  SHALL carry the read data, valid with rsp_valid.
REQ-013 rsp_timeout  output  1  SHALL flag a timed-out read, valid with rsp_valid.
REQ-014 tx_send  output  1  SHALL be a one-cycle pulse telling the UART to transmit tx_data.
REQ-015 tx_data  output  8  SHALL carry the byte to transmit.
REQ-016 tx_busy  input  1  SHALL indicate the UART transmitter is busy.
REQ-017 rx_recieved  input  1  SHALL be a one-cycle pulse marking a received byte.
REQ-018 rx_data  input  8  SHALL carry the received byte, valid with rx_recieved.

Function
REQ-019 FSM states SHALL be IDLE, CMD, ADDR, DATA, GAP, WAIT_RX and DONE.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is taken when req_valid & req_ready, latching req_write, req_addr and req_wdata, then going to CMD.
REQ-021 In CMD, ADDR and DATA, tx_send SHALL pulse for exactly one cycle on the first cycle tx_busy==0; tx_data SHALL hold the byte for that cycle.
REQ-022 In CMD the byte SHALL be CMD_WRITE or CMD_READ; in ADDR the latched address; in DATA the latched wdata.
REQ-023 After each tx_send the FSM SHALL spend one cycle in GAP before the next send state, so a stale tx_busy==0 is never taken as ready.
REQ-024 Send sequence: write = CMD, GAP, ADDR, GAP, DATA, GAP, then wait for tx_busy==0 before DONE; read = CMD, GAP, ADDR, GAP, WAIT_RX.
REQ-025 WAIT_RX SHALL clear the 32-bit timeout counter on entry and increment it once per cycle.
REQ-026 In WAIT_RX, rx_recieved SHALL capture rx_data into rsp_rdata, clear rsp_timeout and go to DONE.
REQ-027 In WAIT_RX, when the counter equals TIMED and no byte is received, the block SHALL set rsp_rdata=0 and rsp_timeout=1 and go to DONE.
REQ-028 If rx_recieved and the timeout occur in the same cycle, the received byte SHALL win.
REQ-029 rx_recieved outside WAIT_RX SHALL be ignored.
REQ-030 DONE SHALL assert rsp_valid for one cycle, then return to IDLE.
REQ-031 A write SHALL complete with rsp_timeout=0 and rsp_rdata=0.
REQ-032 The earliest next request acceptance SHALL be the cycle after DONE.
REQ-033 Latched request fields SHALL NOT change until IDLE.

Reset
REQ-034 While rst=1 the block SHALL force: state IDLE, counter 0, tx_send 0, tx_data 0, rsp_valid 0, rsp_rdata 0, rsp_timeout 0.
REQ-035 req_ready SHALL be 1 once rst deasserts.
REQ-036 A reset asserted mid-transaction SHALL abandon it with no rsp_valid.

Verification
REQ-037 Write addr 8'h05 data 8'hA3, tx_busy idle -> tx_send pulses with 8'h01, 8'h05, 8'hA3 in order; then one rsp_valid with timeout=0.
REQ-038 Read addr 8'h10, rx_recieved with 8'h5C after 100 cycles -> tx bytes 8'h02, 8'h10; rsp_valid with rdata=8'h5C, timeout=0.
REQ-039 Read with no response -> rsp_valid exactly TIMED+1 cycles after WAIT_RX entry, with rdata=0, timeout=1.
REQ-040 tx_busy held high 50 cycles after each send -> no tx_send while busy, one pulse per byte, byte order preserved.
REQ-041 rx_recieved on the timeout cycle -> rdata captured, timeout=0; a stray rx byte in IDLE -> no rsp_valid.
REQ-042 rst asserted during ADDR of a write -> outputs at reset values immediately, no rsp_valid, next request handled normally.
